// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction memory.
// Provides a combinational 10-byte fetch window over the same memory.
module imem_loader #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        load_done,
  output logic [1:0]  load_error,
  output logic [15:0] byte_count,
  input  logic [63:0] rd_addr,
  output logic [79:0] rd_data,
  output logic        rd_error
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_LOAD, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic [7:0]  csum_q, csum_d;
  logic        load_done_q, load_done_d;
  logic [1:0]  load_error_q, load_error_d;
  logic        xfer;
  logic        mem_we;
  logic [64:0] rd_idx;

  // Memory is deliberately left out of reset so an aborted load keeps its bytes.
  logic [7:0]  mem [MEM_BYTES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      byte_count_q <= '0;
      csum_q       <= '0;
      load_done_q  <= 1'b0;
      load_error_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_count_q <= byte_count_d;
      csum_q       <= csum_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign xfer = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_count_d = byte_count_q;
    csum_d       = csum_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_LEN_LO;
          byte_count_d = '0;
          csum_d       = '0;
          load_done_d  = 1'b0;
          load_error_d = 2'd0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d   = {len_q[15:8], in_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = {in_data, len_q[7:0]};
          if ({1'b0, len_d} > 17'(MEM_BYTES)) begin
            state_d      = S_ERR;
            load_error_d = 2'd1;
          end else if (len_d == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          mem_we       = 1'b1;
          csum_d       = csum_q ^ in_data;
          byte_count_d = byte_count_q + 16'd1;
          if (byte_count_d == len_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (in_data == csum_q) begin
            state_d     = S_DONE;
            load_done_d = 1'b1;
          end else begin
            state_d      = S_ERR;
            load_error_d = 2'd2;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_LOAD, S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign byte_count = byte_count_q;

  // byte_count never exceeds len <= MEM_BYTES while writing, so the index stays in range.
  always_ff @(posedge clk) begin
    if (mem_we) mem[byte_count_q[AW-1:0]] <= in_data;
  end

  // Fetch window: each of the 10 bytes is range-checked in 65 bits so nothing wraps.
  always_comb begin
    rd_data = '0;
    rd_idx  = '0;
    for (int i = 0; i < 10; i++) begin
      rd_idx = {1'b0, rd_addr} + 65'(i);
      if (rd_idx < 65'(MEM_BYTES)) rd_data[79-8*i -: 8] = mem[rd_idx[AW-1:0]];
    end
  end

  assign rd_error = ({1'b0, rd_addr} > 65'(MEM_BYTES - 10));

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole-image loads plus hand-written
// sequences for start-while-busy, fetch-window bounds and asynchronous reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        busy;
  logic        load_done;
  logic [1:0]  load_error;
  logic [15:0] byte_count;
  logic [63:0] rd_addr = '0;
  logic [79:0] rd_data;
  logic        rd_error;

  int checks = 0;
  int failures = 0;

  imem_loader #(.MEM_BYTES(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .busy       (busy),
    .load_done  (load_done),
    .load_error (load_error),
    .byte_count (byte_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_error   (rd_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [63:0] b;
    bit          bp;
    logic        done;
    logic [1:0]  err;
    logic [15:0] cnt;
    logic [23:0] mem;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit bp);
    if (bp) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    // stream bytes MSB-first; expected mem is rd_data[79:56] at address 0
    vecs[0] = '{6, 64'h030030F20AC80000, 1'b0, 1'b1, 2'd0, 16'd3, 24'h30F20A};
    vecs[1] = '{5, 64'h02001000FF000000, 1'b0, 1'b0, 2'd2, 16'd2, 24'h10000A};
    vecs[2] = '{2, 64'h0104000000000000, 1'b0, 1'b0, 2'd1, 16'd0, 24'h10000A};
    vecs[3] = '{3, 64'h0000000000000000, 1'b0, 1'b1, 2'd0, 16'd0, 24'h10000A};
    vecs[4] = '{6, 64'h030030F20AC80000, 1'b1, 1'b1, 2'd0, 16'd3, 24'h30F20A};

    #1;
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_in_ready", 80'(in_ready), 80'(0));
    chk("rst_done", 80'(load_done), 80'(0));
    chk("rst_err", 80'(load_error), 80'(0));
    chk("rst_cnt", 80'(byte_count), 80'(0));
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      pulse_start();
      chk($sformatf("v%0d_busy_start", i), 80'(busy), 80'(1));
      for (int k = 0; k < vecs[i].n; k++) send(vecs[i].b[63-8*k -: 8], vecs[i].bp);
      chk($sformatf("v%0d_busy_after", i), 80'(busy), 80'(0));
      chk($sformatf("v%0d_ready_after", i), 80'(in_ready), 80'(0));
      rd_addr = '0;
      #1;
      chk($sformatf("v%0d_done", i), 80'(load_done), 80'(vecs[i].done));
      chk($sformatf("v%0d_err", i), 80'(load_error), 80'(vecs[i].err));
      chk($sformatf("v%0d_cnt", i), 80'(byte_count), 80'(vecs[i].cnt));
      chk($sformatf("v%0d_mem", i), 80'(rd_data[79:56]), 80'(vecs[i].mem));
    end

    // start pulsed during LOAD must not restart the load
    pulse_start();
    send(8'h03, 1'b0);
    send(8'h00, 1'b0);
    send(8'hAA, 1'b0);
    start = 1'b1;
    send(8'hBB, 1'b0);
    start = 1'b0;
    send(8'hCC, 1'b0);
    chk("midstart_busy_check", 80'(busy), 80'(1));
    send(8'hDD, 1'b0);
    chk("midstart_done", 80'(load_done), 80'(1));
    chk("midstart_err", 80'(load_error), 80'(0));
    chk("midstart_cnt", 80'(byte_count), 80'(3));
    rd_addr = '0; #1;
    chk("midstart_mem", 80'(rd_data[79:56]), 80'(24'hAABBCC));

    // fetch window bounds
    rd_addr = 64'd1014; #1;
    chk("rderr_1014", 80'(rd_error), 80'(0));
    rd_addr = 64'd1015; #1;
    chk("rderr_1015", 80'(rd_error), 80'(1));
    rd_addr = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    chk("rderr_max", 80'(rd_error), 80'(1));
    rd_addr = 64'd1020; #1;
    chk("rd_beyond_zero", 80'(rd_data[47:0]), 80'(0));
    rd_addr = 64'd1; #1;
    chk("rd_offset1", 80'(rd_data[79:64]), 80'(16'hBBCC));
    rd_addr = '0;
    @(posedge clk); #1;

    // async reset while streaming the third payload byte
    pulse_start();
    send(8'h04, 1'b0);
    send(8'h00, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h11;
    #1;
    chk("rd_old_same_cycle", 80'(rd_data[79:72]), 80'(8'hAA));
    @(posedge clk); #1;
    chk("rd_new_after_edge", 80'(rd_data[79:72]), 80'(8'h11));
    in_data = 8'h22;
    @(posedge clk); #1;
    in_data = 8'h33;
    chk("arst_cnt_before", 80'(byte_count), 80'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 80'(busy), 80'(0));
    chk("arst_ready", 80'(in_ready), 80'(0));
    chk("arst_done", 80'(load_done), 80'(0));
    chk("arst_err", 80'(load_error), 80'(0));
    chk("arst_cnt", 80'(byte_count), 80'(0));
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("arst_mem_kept", 80'(rd_data[79:56]), 80'(24'h1122CC));
    repeat (3) @(posedge clk);
    #1;
    chk("arst_stays_idle", 80'(busy), 80'(0));
    pulse_start();
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    send(8'h5A, 1'b0);
    send(8'hA5, 1'b0);
    send(8'hFF, 1'b0);
    chk("reload_done", 80'(load_done), 80'(1));
    chk("reload_err", 80'(load_error), 80'(0));
    chk("reload_cnt", 80'(byte_count), 80'(2));
    chk("reload_mem", 80'(rd_data[79:56]), 80'(24'h5AA5CC));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
